// File: rtl/stream_mux_rr.sv
// stream_mux_rr: N-channel streaming multiplexer with valid/ready handshakes
// on every input and a registered output stage. The channel is chosen either
// by an external select (direct mode) or by a round-robin arbiter that scans
// the valid channels starting at a rotating pointer.
module stream_mux_rr #(
   parameter int N_CH   = 8,
   parameter int DATA_W = 8,
   // Derived from N_CH; do not override.
   parameter int SEL_W  = $clog2(N_CH)
) (
   input  logic                   clk,
   input  logic                   rst,
   input  logic [N_CH*DATA_W-1:0] in_data,
   input  logic [N_CH-1:0]        in_valid,
   output logic [N_CH-1:0]        in_ready,
   input  logic                   mode,
   input  logic [SEL_W-1:0]       sel,
   output logic [DATA_W-1:0]      out_data,
   output logic                   out_valid,
   output logic [SEL_W-1:0]       out_ch,
   input  logic                   out_ready
);

   localparam logic [SEL_W-1:0] LAST_CH = SEL_W'(N_CH - 1);
   localparam logic [SEL_W-1:0] ONE_CH  = SEL_W'(1);

   // Output stage and arbitration state.
   logic [DATA_W-1:0] out_data_q,  out_data_d;
   logic              out_valid_q, out_valid_d;
   logic [SEL_W-1:0]  out_ch_q,    out_ch_d;
   logic [SEL_W-1:0]  rr_ptr_q,    rr_ptr_d;

   // Grant network.
   logic              load;
   logic              dir_found;
   logic              rr_found;
   logic              rr_hi_found;
   logic [SEL_W-1:0]  rr_hi_gnt;
   logic [SEL_W-1:0]  rr_lo_gnt;
   logic [SEL_W-1:0]  rr_gnt;
   logic              gnt_found;
   logic [SEL_W-1:0]  gnt;
   logic [DATA_W-1:0] gnt_data;

   // The output register may accept a new beat when empty or draining.
   assign load = !out_valid_q || out_ready;

   // Direct mode: sel grants only if it names an existing, valid channel.
   always_comb begin
      // NOTE: every combinational output gets a default first, so no path
      // through the block leaves it unassigned and infers a latch.
      dir_found = 1'b0;
      for (int i = 0; i < N_CH; i++) begin
         if (sel == SEL_W'(i) && in_valid[i]) dir_found = 1'b1;
      end
   end

   // Round-robin: lowest valid channel at or above rr_ptr, else lowest valid.
   always_comb begin
      rr_hi_found = 1'b0;
      rr_hi_gnt   = '0;
      rr_lo_gnt   = '0;
      rr_found    = 1'b0;
      // Scanning downwards lets the lowest qualifying index win.
      for (int i = N_CH - 1; i >= 0; i--) begin
         if (in_valid[i]) begin
            rr_found  = 1'b1;
            rr_lo_gnt = SEL_W'(i);
            if (SEL_W'(i) >= rr_ptr_q) begin
               rr_hi_found = 1'b1;
               rr_hi_gnt   = SEL_W'(i);
            end
         end
      end
      rr_gnt = rr_hi_found ? rr_hi_gnt : rr_lo_gnt;
   end

   // Pick the grant source for the current mode.
   always_comb begin
      gnt_found = mode ? rr_found : dir_found;
      gnt       = mode ? rr_gnt   : sel;
   end

   // One-hot ready toward the granted producer; held low during reset so a
   // producer never sees a handshake that reset would discard.
   always_comb begin
      in_ready = '0;
      for (int i = 0; i < N_CH; i++) begin
         in_ready[i] = !rst && load && gnt_found && (gnt == SEL_W'(i));
      end
   end

   // Bit-exact slice of the granted channel.
   always_comb begin
      gnt_data = '0;
      for (int i = 0; i < N_CH; i++) begin
         if (gnt == SEL_W'(i)) gnt_data = in_data[i*DATA_W +: DATA_W];
      end
   end

   // Next state of the output register and round-robin pointer.
   always_comb begin
      out_valid_d = out_valid_q;
      out_data_d  = out_data_q;
      out_ch_d    = out_ch_q;
      rr_ptr_d    = rr_ptr_q;
      if (load) begin
         out_valid_d = gnt_found;
         if (gnt_found) begin
            out_data_d = gnt_data;
            out_ch_d   = gnt;
            // Wrap at N_CH, not at 2**SEL_W, so non-power-of-2 sizes stay fair.
            if (mode) rr_ptr_d = (gnt == LAST_CH) ? '0 : gnt + ONE_CH;
         end
      end
   end

   // State registers with synchronous reset that drops any beat in flight.
   always_ff @(posedge clk) begin
      // NOTE: sequential state uses non-blocking assignments so every
      // register samples the pre-edge values, independent of statement order.
      if (rst) begin
         out_valid_q <= 1'b0;
         out_data_q  <= '0;
         out_ch_q    <= '0;
         rr_ptr_q    <= '0;
      end else begin
         out_valid_q <= out_valid_d;
         out_data_q  <= out_data_d;
         out_ch_q    <= out_ch_d;
         rr_ptr_q    <= rr_ptr_d;
      end
   end

   assign out_data  = out_data_q;
   assign out_valid = out_valid_q;
   assign out_ch    = out_ch_q;

endmodule

// File: tb/tb_stream_mux_rr.sv
// tb_stream_mux_rr: drives an 8-channel and a 6-channel instance side by side.
// A behavioural model (modulo scan for round-robin, plain bookkeeping for the
// output register) predicts in_ready and the outputs of both every cycle;
// directed steps add fixed expectations for the key scenarios, then a random
// phase exercises legal producer/consumer traffic.
module tb_stream_mux_rr;

   logic clk = 1'b0;
   always #5 clk = ~clk;

   logic rst;

   logic [63:0] a_in_data;
   logic [7:0]  a_in_valid, a_in_ready;
   logic        a_mode;
   logic [2:0]  a_sel;
   logic [7:0]  a_out_data;
   logic        a_out_valid;
   logic [2:0]  a_out_ch;
   logic        a_out_ready;

   logic [47:0] b_in_data;
   logic [5:0]  b_in_valid, b_in_ready;
   logic        b_mode;
   logic [2:0]  b_sel;
   logic [7:0]  b_out_data;
   logic        b_out_valid;
   logic [2:0]  b_out_ch;
   logic        b_out_ready;

   stream_mux_rr #(.N_CH(8), .DATA_W(8)) u_a (
      .clk(clk), .rst(rst),
      .in_data(a_in_data), .in_valid(a_in_valid), .in_ready(a_in_ready),
      .mode(a_mode), .sel(a_sel),
      .out_data(a_out_data), .out_valid(a_out_valid), .out_ch(a_out_ch),
      .out_ready(a_out_ready)
   );

   stream_mux_rr #(.N_CH(6), .DATA_W(8)) u_b (
      .clk(clk), .rst(rst),
      .in_data(b_in_data), .in_valid(b_in_valid), .in_ready(b_in_ready),
      .mode(b_mode), .sel(b_sel),
      .out_data(b_out_data), .out_valid(b_out_valid), .out_ch(b_out_ch),
      .out_ready(b_out_ready)
   );

   int checks = 0;
   int errors = 0;

   // Reference model state, index 0 = 8-channel instance, 1 = 6-channel.
   bit         m_valid[2];
   logic [7:0] m_data[2];
   int         m_ch[2];
   int         m_ptr[2];
   int         xfer[2];

   int rr_seq[6]   = '{1, 4, 7, 1, 4, 7};
   int wrap_seq[4] = '{5, 0, 5, 0};

   task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   // Grant rule: direct picks sel if it exists and is valid; round-robin takes
   // the first valid channel in the cyclic order ptr, ptr+1, ... mod n.
   function automatic void grant(input logic [63:0] valid, input int n, input logic mode,
                                 input int sel, input int ptr, output bit found, output int g);
      int c;
      found = 1'b0;
      g     = 0;
      if (!mode) begin
         if (sel < n && valid[sel]) begin
            found = 1'b1;
            g     = sel;
         end
      end else begin
         for (int k = 0; k < n; k++) begin
            c = (ptr + k) % n;
            if (!found && valid[c]) begin
               found = 1'b1;
               g     = c;
            end
         end
      end
   endfunction

   task automatic get_io(input int d, output logic [63:0] data, output logic [63:0] valid,
                         output logic mode, output int sel, output logic oready, output int n);
      if (d == 0) begin
         data = a_in_data; valid = {56'd0, a_in_valid}; mode = a_mode;
         sel = int'(a_sel); oready = a_out_ready; n = 8;
      end else begin
         data = {16'd0, b_in_data}; valid = {58'd0, b_in_valid}; mode = b_mode;
         sel = int'(b_sel); oready = b_out_ready; n = 6;
      end
   endtask

   // Let inputs settle, then compare both instances against the model.
   task automatic settle();
      logic [63:0] data, valid, exp_rdy;
      logic mode, oready;
      int sel, n, g;
      bit found;
      #2;
      for (int d = 0; d < 2; d++) begin
         get_io(d, data, valid, mode, sel, oready, n);
         grant(valid, n, mode, sel, m_ptr[d], found, g);
         exp_rdy = (!rst && (!m_valid[d] || oready) && found) ? (64'd1 << g) : 64'd0;
         check($sformatf("model_in_ready_%0d", d),
               (d == 0) ? 64'(a_in_ready) : 64'(b_in_ready), exp_rdy);
         check($sformatf("model_out_valid_%0d", d),
               (d == 0) ? 64'(a_out_valid) : 64'(b_out_valid), 64'(m_valid[d]));
         check($sformatf("model_out_data_%0d", d),
               (d == 0) ? 64'(a_out_data) : 64'(b_out_data), 64'(m_data[d]));
         check($sformatf("model_out_ch_%0d", d),
               (d == 0) ? 64'(a_out_ch) : 64'(b_out_ch), 64'(m_ch[d]));
      end
   endtask

   // Advance one clock edge and update the model with what that edge does.
   task automatic tick();
      logic [63:0] data, valid;
      logic mode, oready;
      int sel, n, g;
      bit found;
      bit         nv[2];
      logic [7:0] nd[2];
      int         nc[2], np[2], nx[2];
      for (int d = 0; d < 2; d++) begin
         get_io(d, data, valid, mode, sel, oready, n);
         grant(valid, n, mode, sel, m_ptr[d], found, g);
         nv[d] = m_valid[d]; nd[d] = m_data[d]; nc[d] = m_ch[d]; np[d] = m_ptr[d]; nx[d] = -1;
         if (rst) begin
            nv[d] = 1'b0; nd[d] = 8'd0; nc[d] = 0; np[d] = 0;
         end else if (!m_valid[d] || oready) begin
            nv[d] = found;
            if (found) begin
               nd[d] = data[g*8 +: 8];
               nc[d] = g;
               nx[d] = g;
               if (mode) np[d] = (g + 1) % n;
            end
         end
      end
      @(posedge clk);
      for (int d = 0; d < 2; d++) begin
         m_valid[d] = nv[d]; m_data[d] = nd[d]; m_ch[d] = nc[d]; m_ptr[d] = np[d]; xfer[d] = nx[d];
      end
      #1;
   endtask

   initial begin
      rst = 1'b1;
      a_in_valid = 8'hFF; b_in_valid = 6'h3F;
      a_mode = 1'b1; b_mode = 1'b1;
      a_sel = 3'd0; b_sel = 3'd0;
      a_out_ready = 1'b1; b_out_ready = 1'b1;
      for (int i = 0; i < 8; i++) a_in_data[i*8 +: 8] = 8'hA0 + 8'(i);
      for (int i = 0; i < 6; i++) b_in_data[i*8 +: 8] = 8'h50 + 8'(i);
      for (int d = 0; d < 2; d++) begin
         m_valid[d] = 1'b0; m_data[d] = 8'd0; m_ch[d] = 0; m_ptr[d] = 0; xfer[d] = -1;
      end

      // Reset, first cycle clears the unknown power-up state.
      @(posedge clk); #1;
      settle();
      check("rst_in_ready", 64'(a_in_ready), 64'h00);
      check("rst_out_valid", 64'(a_out_valid), 64'd0);
      check("rst_out_data", 64'(a_out_data), 64'h00);
      check("rst_out_ch", 64'(a_out_ch), 64'd0);
      tick();
      rst = 1'b0;

      // First round-robin grant after release is ch0.
      settle();
      check("first_rr_grant", 64'(a_in_ready), 64'h01);
      tick();
      a_in_valid = 8'h00;
      settle();
      check("first_rr_out_ch", 64'(a_out_ch), 64'd0);
      check("first_rr_out_valid", 64'(a_out_valid), 64'd1);
      tick();

      // Direct mode.
      a_in_valid = 8'hFF; a_mode = 1'b0; a_sel = 3'd5;
      settle();
      check("dir_in_ready", 64'(a_in_ready), 64'h20);
      tick();
      a_sel = 3'd7; a_in_valid = 8'h7F;
      settle();
      check("dir_out_data", 64'(a_out_data), 64'hA5);
      check("dir_out_ch", 64'(a_out_ch), 64'd5);
      check("dir_out_valid", 64'(a_out_valid), 64'd1);
      check("dir_sel7_in_ready", 64'(a_in_ready), 64'h00);
      tick();
      settle();
      check("dir_no_grant_valid", 64'(a_out_valid), 64'd0);
      tick();

      // Round-robin fairness, pointer still at 1 from the first grant.
      a_mode = 1'b1; a_in_valid = 8'b1001_0010;
      for (int k = 0; k < 6; k++) begin
         settle();
         if (k > 0) check($sformatf("rr_out_ch_%0d", k - 1), 64'(a_out_ch), 64'(rr_seq[k-1]));
         check($sformatf("rr_in_ready_%0d", k), 64'(a_in_ready), 64'd1 << rr_seq[k]);
         tick();
      end

      // Back-pressure holds the ch7 beat and stalls all inputs.
      a_out_ready = 1'b0;
      for (int k = 0; k < 3; k++) begin
         settle();
         check("bp_in_ready", 64'(a_in_ready), 64'h00);
         check("bp_out_ch", 64'(a_out_ch), 64'd7);
         check("bp_out_data", 64'(a_out_data), 64'hA7);
         check("bp_out_valid", 64'(a_out_valid), 64'd1);
         tick();
      end
      a_out_ready = 1'b1;
      settle();
      check("release_in_ready", 64'(a_in_ready), 64'h02);
      tick();
      settle();
      check("release_out_ch", 64'(a_out_ch), 64'd1);
      check("release_out_valid", 64'(a_out_valid), 64'd1);
      tick();

      // Reset during a stalled beat: beat dropped, pointer back to 0.
      a_in_valid = 8'h08;
      settle();
      tick();
      a_out_ready = 1'b0; a_in_valid = 8'hFF;
      settle();
      check("mid_out_ch", 64'(a_out_ch), 64'd3);
      check("mid_stall_ready", 64'(a_in_ready), 64'h00);
      tick();
      rst = 1'b1;
      settle();
      check("mid_rst_in_ready", 64'(a_in_ready), 64'h00);
      tick();
      rst = 1'b0; a_out_ready = 1'b1;
      settle();
      check("mid_out_valid", 64'(a_out_valid), 64'd0);
      check("mid_ptr_reset", 64'(a_in_ready), 64'h01);
      tick();

      // Six channels: wrap from ch5 to ch0.
      b_mode = 1'b1; b_in_valid = 6'b01_0000;
      settle();
      tick();
      b_in_valid = 6'b10_0001;
      for (int k = 0; k < 4; k++) begin
         settle();
         if (k > 0) check($sformatf("wrap_out_ch_%0d", k - 1), 64'(b_out_ch), 64'(wrap_seq[k-1]));
         check($sformatf("wrap_in_ready_%0d", k), 64'(b_in_ready), 64'd1 << wrap_seq[k]);
         tick();
      end
      b_mode = 1'b0; b_in_valid = 6'h3F; b_sel = 3'd6;
      settle();
      check("sel6_in_ready", 64'(b_in_ready), 64'h00);
      tick();
      b_sel = 3'd7;
      settle();
      check("sel7_in_ready", 64'(b_in_ready), 64'h00);
      check("sel_oob_out_valid", 64'(b_out_valid), 64'd0);
      tick();

      // Random legal traffic on both instances, checked by the model.
      for (int cyc = 0; cyc < 400; cyc++) begin
         if (xfer[0] >= 0) a_in_valid[xfer[0]] = 1'b0;
         if (xfer[1] >= 0) b_in_valid[xfer[1]] = 1'b0;
         for (int i = 0; i < 8; i++) begin
            if (!a_in_valid[i] && $urandom_range(1, 0) == 1) begin
               a_in_valid[i] = 1'b1;
               a_in_data[i*8 +: 8] = 8'($urandom);
            end
         end
         for (int i = 0; i < 6; i++) begin
            if (!b_in_valid[i] && $urandom_range(1, 0) == 1) begin
               b_in_valid[i] = 1'b1;
               b_in_data[i*8 +: 8] = 8'($urandom);
            end
         end
         if ($urandom_range(7, 0) == 0) a_mode = ~a_mode;
         if ($urandom_range(7, 0) == 0) b_mode = ~b_mode;
         a_sel = 3'($urandom_range(7, 0));
         b_sel = 3'($urandom_range(7, 0));
         a_out_ready = ($urandom_range(3, 0) != 0);
         b_out_ready = ($urandom_range(3, 0) != 0);
         settle();
         tick();
      end

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
